// File: rtl/arm_defs_pkg.sv
// Shared definitions for the arm_core memory-port arbiter: state encoding,
// word width, alignment helpers and the registered memory command layout.
package arm_defs;

  localparam int WORD_W = 32;
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY_IF = 2'd1,
    ARB_BUSY_D  = 2'd2,
    ARB_HALTED  = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic              we;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } mem_cmd_t;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return |(lsb & ALIGN_MASK);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Ack watchdog: counts non-ack cycles of an access; expired flags the edge on
// which the count would reach LIMIT.
module mem_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_cnt <= '0;
    else if (clear)  r_cnt <= '0;
    else if (enable) r_cnt <= r_cnt + 8'd1;
  end

  // Looks one increment ahead so done lands in the cycle after the LIMIT-th wait.
  assign expired = enable && (r_cnt == 8'(LIMIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and data
// load/store: one access in flight, data priority with a bounded streak.
module mem_port_arbiter
  import arm_defs::*;
#(
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT         = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [WORD_W-1:0] if_addr,
  output logic              if_done,
  output logic [WORD_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [WORD_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic              d_done,
  output logic [WORD_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              halt_req,
  output logic              halted
);

  arb_state_e        r_state, w_state_nxt;
  logic [3:0]        r_streak, w_streak_nxt;
  mem_cmd_t          r_cmd, w_cmd_nxt;
  logic              r_mem_req, w_mem_req_nxt;
  logic              r_if_done, w_if_done_nxt, r_if_err, w_if_err_nxt;
  logic              r_d_done, w_d_done_nxt, r_d_err, w_d_err_nxt;
  logic [WORD_W-1:0] r_if_rdata, w_if_rdata_nxt, r_d_rdata, w_d_rdata_nxt;
  logic              r_halted, w_halted_nxt;
  logic              w_wd_clr, w_wd_en, w_wd_expired, w_busy;

  assign w_busy  = (r_state == ARB_BUSY_IF) || (r_state == ARB_BUSY_D);
  assign w_wd_en = w_busy && !mem_ack;

  mem_watchdog #(.LIMIT(TIMEOUT)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_wd_clr),
    .enable  (w_wd_en),
    .expired (w_wd_expired)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_streak_nxt   = r_streak;
    w_cmd_nxt      = r_cmd;
    w_mem_req_nxt  = r_mem_req;
    w_if_done_nxt  = 1'b0;
    w_if_err_nxt   = 1'b0;
    w_d_done_nxt   = 1'b0;
    w_d_err_nxt    = 1'b0;
    w_if_rdata_nxt = r_if_rdata;
    w_d_rdata_nxt  = r_d_rdata;
    w_halted_nxt   = r_halted;
    w_wd_clr       = 1'b0;
    unique case (r_state)
      ARB_IDLE: begin
        if (halt_req) begin
          w_state_nxt  = ARB_HALTED;
          w_halted_nxt = 1'b1;
        end else if (d_req && is_misaligned(d_addr[1:0])) begin
          w_d_done_nxt = 1'b1;
          w_d_err_nxt  = 1'b1;
        end else if (d_req && (!if_req || (r_streak < 4'(MAX_DATA_STREAK)))) begin
          w_state_nxt   = ARB_BUSY_D;
          // Streak only counts data grants that made a waiting fetch wait.
          w_streak_nxt  = if_req ? r_streak + 4'd1 : 4'd0;
          w_cmd_nxt     = '{we: d_we, addr: d_addr, wdata: d_wdata};
          w_mem_req_nxt = 1'b1;
          w_wd_clr      = 1'b1;
        end else if (if_req) begin
          w_state_nxt   = ARB_BUSY_IF;
          w_streak_nxt  = 4'd0;
          w_cmd_nxt.we  = 1'b0;
          w_cmd_nxt.addr = if_addr;
          w_mem_req_nxt = 1'b1;
          w_wd_clr      = 1'b1;
        end
      end
      ARB_BUSY_IF, ARB_BUSY_D: begin
        if (mem_ack || w_wd_expired) begin
          w_state_nxt   = ARB_IDLE;
          w_mem_req_nxt = 1'b0;
          w_cmd_nxt.we  = 1'b0;
          if (r_state == ARB_BUSY_IF) begin
            w_if_done_nxt = 1'b1;
            w_if_err_nxt  = !mem_ack;
            if (mem_ack) w_if_rdata_nxt = mem_rdata;
          end else begin
            w_d_done_nxt = 1'b1;
            w_d_err_nxt  = !mem_ack;
            if (mem_ack) w_d_rdata_nxt = mem_rdata;
          end
        end
      end
      ARB_HALTED: begin
        w_mem_req_nxt = 1'b0;
        w_halted_nxt  = 1'b1;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ARB_IDLE;
      r_streak   <= '0;
      r_cmd      <= '0;
      r_mem_req  <= 1'b0;
      r_if_done  <= 1'b0;
      r_if_err   <= 1'b0;
      r_d_done   <= 1'b0;
      r_d_err    <= 1'b0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_halted   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_streak   <= w_streak_nxt;
      r_cmd      <= w_cmd_nxt;
      r_mem_req  <= w_mem_req_nxt;
      r_if_done  <= w_if_done_nxt;
      r_if_err   <= w_if_err_nxt;
      r_d_done   <= w_d_done_nxt;
      r_d_err    <= w_d_err_nxt;
      r_if_rdata <= w_if_rdata_nxt;
      r_d_rdata  <= w_d_rdata_nxt;
      r_halted   <= w_halted_nxt;
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_cmd.we;
  assign mem_addr  = r_cmd.addr;
  assign mem_wdata = r_cmd.wdata;
  assign if_done   = r_if_done;
  assign if_err    = r_if_err;
  assign if_rdata  = r_if_rdata;
  assign d_done    = r_d_done;
  assign d_err     = r_d_err;
  assign d_rdata   = r_d_rdata;
  assign halted    = r_halted;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random-stimulus bench for mem_port_arbiter against a transaction-level
// model of the arbitration, streak, timeout and halt rules.
module tb_mem_port_arbiter;

  localparam int MAXS = 4;
  localparam int TO   = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ack = 1'b0, halt_req = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic        if_done, if_err, d_done, d_err, mem_req, mem_we, halted;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  mem_port_arbiter #(.MAX_DATA_STREAK(MAXS), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .halt_req(halt_req), .halted(halted)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int ack_pct = 100, req_pct = 100;

  // Reference model: who owns the port (0 none, 1 fetch, 2 data) and what
  // every output should read after the current edge.
  int          m_own, m_wait, m_streak;
  logic        m_halted;
  logic        e_mem_req, e_mem_we, e_if_done, e_if_err, e_d_done, e_d_err;
  logic [31:0] e_mem_addr, e_mem_wdata, e_if_rdata, e_d_rdata;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own = 0; m_wait = 0; m_streak = 0; m_halted = 1'b0;
    e_mem_req = 0; e_mem_we = 0; e_if_done = 0; e_if_err = 0; e_d_done = 0; e_d_err = 0;
    e_mem_addr = '0; e_mem_wdata = '0; e_if_rdata = '0; e_d_rdata = '0;
  endtask

  task automatic model_edge();
    logic fin, err;
    fin = 1'b0; err = 1'b0;
    e_if_done = 0; e_if_err = 0; e_d_done = 0; e_d_err = 0;
    if (m_halted) begin
      e_mem_req = 0;
    end else if (m_own == 0) begin
      if (halt_req) m_halted = 1'b1;
      else if (d_req && d_addr[1:0] != 2'b00) begin
        e_d_done = 1; e_d_err = 1;
      end else if (d_req && (!if_req || m_streak < MAXS)) begin
        m_own = 2; m_wait = 0;
        m_streak = if_req ? m_streak + 1 : 0;
        e_mem_req = 1; e_mem_we = d_we; e_mem_addr = d_addr; e_mem_wdata = d_wdata;
      end else if (if_req) begin
        m_own = 1; m_wait = 0; m_streak = 0;
        e_mem_req = 1; e_mem_we = 0; e_mem_addr = if_addr;
      end
    end else begin
      if (mem_ack) fin = 1'b1;
      else begin
        m_wait++;
        if (m_wait == TO) begin fin = 1'b1; err = 1'b1; end
      end
      if (fin) begin
        if (m_own == 1) begin
          e_if_done = 1; e_if_err = err;
          if (!err) e_if_rdata = mem_rdata;
        end else begin
          e_d_done = 1; e_d_err = err;
          if (!err) e_d_rdata = mem_rdata;
        end
        m_own = 0; e_mem_req = 0; e_mem_we = 0;
      end
    end
  endtask

  task automatic compare();
    chk("mem_req", mem_req, e_mem_req);
    chk("mem_we", mem_we, e_mem_we);
    if (e_mem_req) begin
      chk("mem_addr", mem_addr, e_mem_addr);
      if (m_own == 2) chk("mem_wdata", mem_wdata, e_mem_wdata);
    end
    chk("if_done_err", {if_done, if_err}, {e_if_done, e_if_err});
    chk("if_rdata", if_rdata, e_if_rdata);
    chk("d_done_err", {d_done, d_err}, {e_d_done, e_d_err});
    chk("d_rdata", d_rdata, e_d_rdata);
    chk("halted", halted, m_halted);
  endtask

  // Requests are held until their done; in the done cycle (or when idle)
  // the requester picks afresh, so a still-high request is a new one.
  task automatic drive_next();
    if (!(if_req && !e_if_done)) begin
      if_req  = ($urandom_range(0, 99) < req_pct);
      if_addr = $urandom() & 32'hFFFF_FFFC;
    end
    if (!(d_req && !e_d_done)) begin
      d_req   = ($urandom_range(0, 99) < req_pct);
      d_we    = 1'($urandom_range(0, 1));
      d_wdata = $urandom();
      d_addr  = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) d_addr[1:0] = 2'($urandom_range(1, 3));
    end
    mem_ack   = e_mem_req && ($urandom_range(0, 99) < ack_pct);
    mem_rdata = $urandom();
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
    drive_next();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem"}, {mem_req, mem_we, mem_addr, mem_wdata}, '0);
    chk({tag, "_done"}, {if_done, if_err, d_done, d_err, halted}, '0);
    chk({tag, "_rdata"}, {if_rdata, d_rdata}, '0);
  endtask

  initial begin
    int n;
    model_reset();
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    drive_next();

    for (int c = 0; c < 3000; c++) begin
      case ((c / 300) % 5)
        0: begin req_pct = 70;  ack_pct = 60;  end
        1: begin req_pct = 100; ack_pct = 100; end
        2: begin req_pct = 40;  ack_pct = 30;  end
        3: begin req_pct = 100; ack_pct = 5;   end
        default: begin req_pct = 60; ack_pct = 90; end
      endcase
      step();
    end

    // Halt while traffic is running: in-flight access finishes, then park.
    req_pct = 100; ack_pct = 40;
    halt_req = 1'b1;
    for (int c = 0; c < 40; c++) step();
    chk("halt_parked", {halted, mem_req}, 2'b10);

    // Abandon an access with an asynchronous reset.
    halt_req = 1'b0;
    rst = 1'b0;
    model_reset();
    mem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    ack_pct = 0;
    n = 0;
    while (!e_mem_req && n < 20) begin step(); n++; end
    chk("grant_seen", mem_req, 1'b1);
    #2 rst = 1'b0;
    #1 chk_all_zero("async_rst");
    model_reset();
    if_req = 0; d_req = 0; mem_ack = 0;
    @(negedge clk);
    rst = 1'b1;
    req_pct = 80; ack_pct = 70;
    drive_next();
    for (int c = 0; c < 300; c++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
